// File: rtl/mioc_manchester_dec.sv
// mioc_manchester_dec: Manchester (data XNOR bitclk) line decoder.
// Oversamples the idle-high line, resynchronises on mid-bit transitions,
// recovers LSB-first bytes and presents them on a valid/ready handshake.
// Optional build macro MIOC_MDEC_PARITY_EN adds one even-parity bit after
// data bit 7; a parity mismatch raises code_err and drops the byte.
module mioc_manchester_dec #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       code_err,
    output logic       overrun
);

    localparam int N  = OVERSAMPLE;
    localparam int CW = $clog2(N);
    localparam int HW = $clog2(N / 2 + 1);

    localparam logic [CW-1:0] C_A    = CW'(N / 4);
    localparam logic [CW-1:0] C_B    = CW'(3 * N / 4);
    localparam logic [CW-1:0] C_MID  = CW'(N / 2);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [HW-1:0] H_ARM  = HW'(N / 2);

`ifdef MIOC_MDEC_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] DATA    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    logic          sync1, sync2, line_d;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hicnt;
    logic [3:0]    bidx;
    logic          samp_a;
    logic [7:0]    shreg;
`ifdef MIOC_MDEC_PARITY_EN
    logic          par;
`endif

    logic line, line_edge, line_fall;

    assign line      = sync2;
    assign line_edge = sync2 ^ line_d;
    assign line_fall = line_d & ~sync2;
    assign busy      = (state != IDLE);

    // Two-flop synchronizer followed by the edge-detect register (idle high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= line_in;
            sync2  <= sync1;
            line_d <= sync2;
        end
    end

    // Frame FSM: arming, bit timing with mid-bit resync, half-bit sampling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hicnt    <= '0;
            bidx     <= '0;
            samp_a   <= 1'b0;
            shreg    <= '0;
            code_err <= 1'b0;
`ifdef MIOC_MDEC_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            code_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    bidx <= '0;
                    if (line_fall && hicnt == H_ARM) begin
                        state <= START;
                        hicnt <= '0;
                    end else if (line) begin
                        if (hicnt != H_ARM) hicnt <= hicnt + 1'b1;
                    end else begin
                        hicnt <= '0;
                    end
                end
                START, DATA: begin
                    hicnt <= '0;
                    if (line_edge && cnt > C_A && cnt < C_B)
                        cnt <= C_MID;
                    else if (cnt == C_LAST)
                        cnt <= '0;
                    else
                        cnt <= cnt + 1'b1;

                    if (cnt == C_A) samp_a <= line;

                    if (cnt == C_B) begin
                        if (state == START) begin
                            if (!samp_a && line) begin
                                state <= DATA;
                                bidx  <= '0;
`ifdef MIOC_MDEC_PARITY_EN
                                par   <= 1'b0;
`endif
                            end else begin
                                code_err <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (samp_a == line) begin
                            code_err <= 1'b1;
                            state    <= IDLE;
                        end else begin
`ifdef MIOC_MDEC_PARITY_EN
                            if (bidx == LAST_BIT) begin
                                if (par ^ samp_a) begin
                                    code_err <= 1'b1;
                                    state    <= IDLE;
                                end else begin
                                    state <= DELIVER;
                                end
                            end else begin
                                shreg <= {samp_a, shreg[7:1]};
                                par   <= par ^ samp_a;
                                bidx  <= bidx + 4'd1;
                            end
`else
                            shreg <= {samp_a, shreg[7:1]};
                            bidx  <= bidx + 4'd1;
                            if (bidx == LAST_BIT) state <= DELIVER;
`endif
                        end
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register and valid/ready handshake with overrun detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (state == DELIVER) begin
                if (!valid || ready) begin
                    data_out <= shreg;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mioc_manchester_dec.sv
// Directed testbench for mioc_manchester_dec (OVERSAMPLE=8).
// Line stimulus changes on falling clock edges; handshake events are
// tallied on rising edges using the values the DUT itself saw.
module tb_mioc_manchester_dec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_in;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       code_err;
    logic       overrun;

    int n_asserts = 0;
    int n_fail    = 0;

    int         xfer_cnt  = 0;
    int         cerr_cnt  = 0;
    int         ovr_cnt   = 0;
    logic [7:0] last_data = 8'h00;

    int x0, e0, o0;

    always #5 clk = ~clk;

    mioc_manchester_dec #(.OVERSAMPLE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (line_in),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .code_err (code_err),
        .overrun  (overrun)
    );

    // Tally transfers and error pulses as seen at each active edge.
    always @(posedge clk) begin
        if (valid && ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_data <= data_out;
        end
        if (code_err) cerr_cnt <= cerr_cnt + 1;
        if (overrun)  ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half(input logic v, input int n);
        line_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int h1, input int h2);
        half(v, h1);
        half(~v, h2);
    endtask

    // bad: bit index sent with both halves high (frame then abandoned).
    // rstbit: bit index during which rst_n is pulsed low for one cycle.
    task automatic send_frame(input logic [7:0] b, input int h1, input int h2,
                              input int bad, input int rstbit, input logic par_flip);
        send_bit(1'b0, h1, h2);
        for (int i = 0; i < 8; i++) begin
            if (i == bad) begin
                half(1'b1, h1 + h2);
                return;
            end
            if (i == rstbit) begin
                line_in = b[i];
                repeat (2) @(negedge clk);
                chk("busy_mid_frame", {31'd0, busy}, 32'd1);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                line_in = 1'b1;
                return;
            end
            send_bit(b[i], h1, h2);
        end
`ifdef MIOC_MDEC_PARITY_EN
        send_bit((^b) ^ par_flip, h1, h2);
`else
        if (par_flip) line_in = 1'b1;
`endif
        line_in = 1'b1;
    endtask

    task automatic gap();
        line_in = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic snap();
        x0 = xfer_cnt;
        e0 = cerr_cnt;
        o0 = ovr_cnt;
    endtask

    initial begin
        rst_n   = 1'b0;
        line_in = 1'b1;
        ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, data_out}, 32'h00);
        chk("reset_valid",    {31'd0, valid},    32'd0);
        chk("reset_busy",     {31'd0, busy},     32'd0);
        chk("reset_code_err", {31'd0, code_err}, 32'd0);
        chk("reset_overrun",  {31'd0, overrun},  32'd0);
        rst_n = 1'b1;
        gap();

        // Single frame, consumer always ready.
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 4, 4, -1, -1, 1'b0);
        gap();
        chk("a5_xfers",   xfer_cnt - x0, 32'd1);
        chk("a5_data",    {24'd0, last_data}, 32'hA5);
        chk("a5_cerr",    cerr_cnt - e0, 32'd0);
        chk("a5_overrun", ovr_cnt - o0,  32'd0);
        chk("a5_valid_cleared", {31'd0, valid}, 32'd0);

        // Two frames with consumer stalled: second byte is dropped.
        ready = 1'b0;
        snap();
        send_frame(8'h3C, 4, 4, -1, -1, 1'b0);
        gap();
        send_frame(8'hC3, 4, 4, -1, -1, 1'b0);
        gap();
        chk("stall_overrun", ovr_cnt - o0, 32'd1);
        chk("stall_data",    {24'd0, data_out}, 32'h3C);
        chk("stall_valid",   {31'd0, valid}, 32'd1);
        chk("stall_cerr",    cerr_cnt - e0, 32'd0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        chk("stall_valid_drop", {31'd0, valid}, 32'd0);

        // Coding violation at data bit 3, then recovery.
        ready = 1'b1;
        snap();
        send_frame(8'h00, 4, 4, 3, -1, 1'b0);
        gap();
        chk("viol_cerr",  cerr_cnt - e0, 32'd1);
        chk("viol_xfers", xfer_cnt - x0, 32'd0);
        chk("viol_busy",  {31'd0, busy}, 32'd0);
        snap();
        send_frame(8'h11, 4, 4, -1, -1, 1'b0);
        gap();
        chk("recover_xfers", xfer_cnt - x0, 32'd1);
        chk("recover_data",  {24'd0, last_data}, 32'h11);

        // Bit period stretched to 9 clocks.
        snap();
        send_frame(8'hFF, 4, 5, -1, -1, 1'b0);
        gap();
        chk("drift_xfers", xfer_cnt - x0, 32'd1);
        chk("drift_data",  {24'd0, last_data}, 32'hFF);
        chk("drift_cerr",  cerr_cnt - e0, 32'd0);
        chk("drift_data_out", {24'd0, data_out}, 32'hFF);

        // Reset pulse during data bit 4.
        snap();
        send_frame(8'h96, 4, 4, -1, 4, 1'b0);
        @(negedge clk);
        chk("midrst_data_out", {24'd0, data_out}, 32'h00);
        chk("midrst_valid",    {31'd0, valid},    32'd0);
        chk("midrst_busy",     {31'd0, busy},     32'd0);
        chk("midrst_code_err", {31'd0, code_err}, 32'd0);
        chk("midrst_overrun",  {31'd0, overrun},  32'd0);
        gap();
        chk("midrst_xfers", xfer_cnt - x0, 32'd0);
        chk("midrst_cerr",  cerr_cnt - e0, 32'd0);
        snap();
        send_frame(8'h5A, 4, 4, -1, -1, 1'b0);
        gap();
        chk("post_rst_xfers", xfer_cnt - x0, 32'd1);
        chk("post_rst_data",  {24'd0, last_data}, 32'h5A);

`ifdef MIOC_MDEC_PARITY_EN
        // Even parity: correct bit accepted, flipped bit rejected.
        snap();
        send_frame(8'h07, 4, 4, -1, -1, 1'b0);
        gap();
        chk("par_ok_xfers", xfer_cnt - x0, 32'd1);
        chk("par_ok_data",  {24'd0, last_data}, 32'h07);
        chk("par_ok_cerr",  cerr_cnt - e0, 32'd0);
        snap();
        send_frame(8'h07, 4, 4, -1, -1, 1'b1);
        gap();
        chk("par_bad_cerr",  cerr_cnt - e0, 32'd1);
        chk("par_bad_xfers", xfer_cnt - x0, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
